hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_muldiv_timer.sv | 80 ++++++++
 rtl/hazard_ctrl.sv | 83 ++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: stage control codes,
// mul/div timer states and counter width.
package hazard_ctrl_pkg;

  localparam int unsigned HZ_W  = 2;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned REG_W = 5;

  typedef enum logic [HZ_W-1:0] {
    HZ_NORMAL = 2'b00,
    HZ_FLUSH  = 2'b01,
    HZ_STALL  = 2'b10
  } hz_ctrl_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_muldiv_timer.sv
// HI/LO occupancy timer: tracks how long an accepted mul/div keeps HI/LO busy.
// Divide timing is present only when HAZARD_CTRL_DIV_EN is defined.
module muldiv_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
`ifdef HAZARD_CTRL_DIV_EN
  ,
  parameter int unsigned DIV_CYCLES = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef HAZARD_CTRL_DIV_EN
  input  logic is_div,
`endif
  output logic busy
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
`ifdef HAZARD_CTRL_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
`endif

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs LOAD..0, so busy lasts exactly LOAD+1 cycles after the start edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
`ifdef HAZARD_CTRL_DIV_EN
          if (is_div) begin
            state_d = MD_DIV;
            cnt_d   = DIV_LOAD;
          end else begin
            state_d = MD_MUL;
            cnt_d   = MUL_LOAD;
          end
`else
          state_d = MD_MUL;
          cnt_d   = MUL_LOAD;
`endif
        end
      end
`ifdef HAZARD_CTRL_DIV_EN
      MD_MUL, MD_DIV: begin
`else
      MD_MUL: begin
`endif
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != MD_IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch/jump flushes, load-use and HI/LO stalls,
// mul/div acceptance. Optional divide timing via HAZARD_CTRL_DIV_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRd,
  input  logic [REG_W-1:0] ID_EX_RtAddr,
  input  logic [REG_W-1:0] IF_ID_RsAddr,
  input  logic [REG_W-1:0] IF_ID_RtAddr,
  input  logic             EX_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_MulDiv,
  input  logic             ID_IsDiv,
  input  logic             ID_UsesHiLo,
  output logic [HZ_W-1:0]  PC_HzCtrl,
  output logic [HZ_W-1:0]  IF_ID_HzCtrl,
  output logic [HZ_W-1:0]  ID_EX_HzCtrl,
  output logic             MulDivBusy,
  output logic             MulDivStart
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 63 || DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_bad_cfg
    $error("hazard_ctrl: MUL_CYCLES/DIV_CYCLES must be within 1..63");
  end

  logic load_use;
  logic hilo_wait;

  assign load_use = ID_EX_MemRd && (ID_EX_RtAddr != '0) &&
                    ((ID_EX_RtAddr == IF_ID_RsAddr) || (ID_EX_RtAddr == IF_ID_RtAddr));
  assign hilo_wait = MulDivBusy && (ID_UsesHiLo || ID_MulDiv);

  // Taken branch outranks stalls; a stall outranks a jump flush.
  always_comb begin
    PC_HzCtrl    = HZ_NORMAL;
    IF_ID_HzCtrl = HZ_NORMAL;
    ID_EX_HzCtrl = HZ_NORMAL;
    if (EX_BranchTaken) begin
      IF_ID_HzCtrl = HZ_FLUSH;
      ID_EX_HzCtrl = HZ_FLUSH;
    end else if (load_use || hilo_wait) begin
      PC_HzCtrl    = HZ_STALL;
      IF_ID_HzCtrl = HZ_STALL;
      ID_EX_HzCtrl = HZ_FLUSH;
    end else if (ID_Jump) begin
      IF_ID_HzCtrl = HZ_FLUSH;
    end
  end

  assign MulDivStart = ID_MulDiv && (ID_EX_HzCtrl == HZ_W'(HZ_NORMAL));

`ifdef HAZARD_CTRL_DIV_EN
  muldiv_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (MulDivStart),
    .is_div(ID_IsDiv),
    .busy  (MulDivBusy)
  );
`else
  // Without divide support every mul/div is timed as a multiply.
  logic unused_is_div;
  assign unused_is_div = ID_IsDiv;

  muldiv_timer #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(MulDivStart),
    .busy (MulDivBusy)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; honours HAZARD_CTRL_DIV_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_DIV_EN
  localparam int DIV_N  = 32;
  localparam int RST_AT = 10;
`else
  localparam int DIV_N  = 4;
  localparam int RST_AT = 2;
`endif
  localparam int MUL_N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_EX_MemRd;
  logic [4:0] ID_EX_RtAddr, IF_ID_RsAddr, IF_ID_RtAddr;
  logic       EX_BranchTaken, ID_Jump, ID_MulDiv, ID_IsDiv, ID_UsesHiLo;
  logic [1:0] PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl;
  logic       MulDivBusy, MulDivStart;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRd(ID_EX_MemRd), .ID_EX_RtAddr(ID_EX_RtAddr),
    .IF_ID_RsAddr(IF_ID_RsAddr), .IF_ID_RtAddr(IF_ID_RtAddr),
    .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv), .ID_UsesHiLo(ID_UsesHiLo),
    .PC_HzCtrl(PC_HzCtrl), .IF_ID_HzCtrl(IF_ID_HzCtrl), .ID_EX_HzCtrl(ID_EX_HzCtrl),
    .MulDivBusy(MulDivBusy), .MulDivStart(MulDivStart)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ID_EX_MemRd = 0; ID_EX_RtAddr = 0; IF_ID_RsAddr = 0; IF_ID_RtAddr = 0;
    EX_BranchTaken = 0; ID_Jump = 0; ID_MulDiv = 0; ID_IsDiv = 0; ID_UsesHiLo = 0;
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Compare {PC, IF_ID, ID_EX, busy, start} against the expected vector.
  task automatic chk(input string tag, input logic [1:0] pc, input logic [1:0] ifid,
                     input logic [1:0] idex, input logic busy, input logic start);
    logic [7:0] obs, exp;
    #1;
    obs = {PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, MulDivBusy, MulDivStart};
    exp = {pc, ifid, idex, busy, start};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count remaining busy cycles, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (MulDivBusy === 1'b1 && n < 100) begin
      n++;
      cyc();
      #1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle_inputs();
    chk("reset_state", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("post_reset_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // lw $2 in EX, ID reads $2 as rs
    ID_EX_MemRd = 1; ID_EX_RtAddr = 5'd2; IF_ID_RsAddr = 5'd2; IF_ID_RtAddr = 5'd7;
    chk("load_use_rs", 2'b10, 2'b10, 2'b01, 1'b0, 1'b0);
    cyc();
    idle_inputs();
    chk("load_use_release", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    ID_EX_MemRd = 1; ID_EX_RtAddr = 5'd5; IF_ID_RsAddr = 5'd3; IF_ID_RtAddr = 5'd5;
    chk("load_use_rt", 2'b10, 2'b10, 2'b01, 1'b0, 1'b0);

    ID_EX_RtAddr = 5'd0; IF_ID_RsAddr = 5'd0; IF_ID_RtAddr = 5'd0;
    chk("load_r0_no_stall", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    ID_EX_MemRd = 0; ID_EX_RtAddr = 5'd9; IF_ID_RsAddr = 5'd9;
    chk("non_load_match", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    idle_inputs(); ID_Jump = 1;
    chk("jump_flush", 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);

    idle_inputs(); EX_BranchTaken = 1; ID_Jump = 1;
    chk("branch_flush", 2'b00, 2'b01, 2'b01, 1'b0, 1'b0);

    // mult accepted, mfhi waits exactly MUL_N cycles
    idle_inputs(); ID_MulDiv = 1;
    chk("mult_start", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    idle_inputs(); ID_UsesHiLo = 1;
    for (int i = 0; i < MUL_N; i++) begin
      chk($sformatf("mfhi_stall_%0d", i), 2'b10, 2'b10, 2'b01, 1'b1, 1'b0);
      cyc();
    end
    chk("mfhi_proceeds", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // taken branch during busy does not abort; second mult in ID is stalled
    idle_inputs(); ID_MulDiv = 1;
    cyc();
    idle_inputs(); EX_BranchTaken = 1; ID_UsesHiLo = 1;
    chk("branch_during_busy", 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
    cyc();
    idle_inputs(); ID_MulDiv = 1;
    chk("mult_while_busy", 2'b10, 2'b10, 2'b01, 1'b1, 1'b0);
    ID_MulDiv = 0;
    count_busy(n);
    chk_int("busy_after_branch", n, MUL_N - 1);

    // branch + load-use + mul/div: flush wins, FSM stays idle
    idle_inputs(); EX_BranchTaken = 1; ID_MulDiv = 1;
    ID_EX_MemRd = 1; ID_EX_RtAddr = 5'd4; IF_ID_RsAddr = 5'd4;
    chk("branch_vs_muldiv", 2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
    cyc();
    idle_inputs();
    chk("fsm_stayed_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // divide latency depends on the build
    ID_MulDiv = 1; ID_IsDiv = 1;
    chk("div_start", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    idle_inputs();
    #1;
    count_busy(n);
    chk_int("div_busy_cycles", n, DIV_N);

    // reset in the middle of a divide
    idle_inputs(); ID_MulDiv = 1; ID_IsDiv = 1;
    cyc();
    idle_inputs(); ID_UsesHiLo = 1;
    for (int i = 1; i < RST_AT; i++) cyc();
    chk("div_busy_before_rst", 2'b10, 2'b10, 2'b01, 1'b1, 1'b0);
    rst = 1'b1;
    chk("rst_mid_div", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("after_rst_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
